// File: rtl/sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer
//
// Ring-counter T-state generator and control matrix for the SAP CPU. Each
// instruction takes six T-states. T1-T3 fetch the instruction and T4-T6
// execute it. The module takes the one-hot opcode lines from the 4-to-16
// decoder and produces the 12-bit control word. It also raises the halt
// request to the clock gate.
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   clr           synchronous active-high reset; overrides everything, halt too
//   instr_onehot  one-hot opcode from the decoder; only looked at in T4-T6
//   t_state       one-hot T-state, bit0 = T1 ... bit5 = T6
//   con           control word {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}
//   halt          stop request to the clock gate
//   decode_err    sticky flag: malformed opcode seen in T4, cleared by clr
// -----------------------------------------------------------------------------
module sap_control_sequencer #(
    parameter int LDA_OP = 0,
    parameter int ADD_OP = 1,
    parameter int SUB_OP = 2,
    parameter int OUT_OP = 14,
    parameter int HLT_OP = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] instr_onehot,
    output logic [5:0]  t_state,
    output logic [11:0] con,
    output logic        halt,
    output logic        decode_err
);

    // Control word bit positions, bit11 down to bit0.
    localparam logic [11:0] CP = 12'h800;  // increment program counter
    localparam logic [11:0] EP = 12'h400;  // PC onto bus
    localparam logic [11:0] LM = 12'h200;  // load MAR
    localparam logic [11:0] CE = 12'h100;  // RAM onto bus
    localparam logic [11:0] LI = 12'h080;  // load IR
    localparam logic [11:0] EI = 12'h040;  // IR address field onto bus
    localparam logic [11:0] LA = 12'h020;  // load accumulator
    localparam logic [11:0] EA = 12'h010;  // accumulator onto bus
    localparam logic [11:0] SU = 12'h008;  // ALU subtract
    localparam logic [11:0] EU = 12'h004;  // ALU onto bus
    localparam logic [11:0] LB = 12'h002;  // load B register
    localparam logic [11:0] LO = 12'h001;  // load output register

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } tstate_e;

    tstate_e state_q, state_d;
    logic    halted_q, halted_d;
    logic    err_d;
    // Set when this instruction's opcode was malformed in T4. It keeps T5/T6
    // as NOPs even if the decoder lines change to a legal opcode later.
    logic    bad_q, bad_d;
    logic    op_valid;

    assign t_state = state_q;

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
    assign op_valid = (instr_onehot != 16'd0) &&
                      ((instr_onehot & (instr_onehot - 16'd1)) == 16'd0);

    assign halt = halted_q | (state_q[3] & instr_onehot[HLT_OP] & op_valid);

    // Execute-phase word. step 0/1/2 = T4/T5/T6. The caller guarantees that op
    // is one-hot, so the if-chain priority has no effect.
    function automatic logic [11:0] exec_word(input logic [1:0] step,
                                              input logic [15:0] op);
        logic [11:0] w;
        w = 12'h000;
        if (op[LDA_OP]) begin
            case (step)
                2'd0:    w = EI | LM;
                2'd1:    w = CE | LA;
                default: w = 12'h000;
            endcase
        end else if (op[ADD_OP]) begin
            case (step)
                2'd0:    w = EI | LM;
                2'd1:    w = CE | LB;
                default: w = EU | LA;
            endcase
        end else if (op[SUB_OP]) begin
            case (step)
                2'd0:    w = EI | LM;
                2'd1:    w = CE | LB;
                default: w = SU | EU | LA;
            endcase
        end else if (op[OUT_OP]) begin
            if (step == 2'd0) w = EA | LO;
        end
        // HLT and every other single-bit opcode leave w at 12'h000 (NOP).
        return w;
    endfunction

    // Next state and control word.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        halted_d = halted_q;
        err_d    = decode_err;
        bad_d    = bad_q;
        con      = 12'h000;

        // While halted the counter is frozen and the word stays all-zero.
        if (!halted_q) begin
            case (state_q)
                T1: begin
                    state_d = T2;
                    con     = EP | LM;
                end
                T2: begin
                    state_d = T3;
                    con     = CP;
                end
                T3: begin
                    state_d = T4;
                    con     = CE | LI;
                end
                T4: begin
                    state_d = T5;
                    bad_d   = !op_valid;
                    if (!op_valid) err_d = 1'b1;
                    con = op_valid ? exec_word(2'd0, instr_onehot) : 12'h000;
                    if (op_valid && instr_onehot[HLT_OP]) begin
                        halted_d = 1'b1;
                        state_d  = T4;
                    end
                end
                T5: begin
                    state_d = T6;
                    con = (op_valid && !bad_q) ? exec_word(2'd1, instr_onehot)
                                               : 12'h000;
                end
                T6: begin
                    state_d = T1;
                    bad_d   = 1'b0;
                    con = (op_valid && !bad_q) ? exec_word(2'd2, instr_onehot)
                                               : 12'h000;
                end
                // Not reachable from reset. Recovers to fetch if it ever happens.
                default: state_d = T1;
            endcase
        end
    end

    // State register; clr wins over everything, including a pending halt.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its pre-edge inputs, whatever the order of the statements.
        if (clr) begin
            state_q    <= T1;
            halted_q   <= 1'b0;
            decode_err <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            decode_err <= err_d;
            bad_q      <= bad_d;
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_control_sequencer
//
// Each stimulus row gives one clock cycle of inputs and the outputs that cycle
// must show. Inputs change 1 ns after the rising edge, and the expected outputs
// go into a scoreboard queue at the same moment. A monitor pops each entry on
// the next falling edge and compares it against the DUT outputs. A table covers
// the plain instruction flow. Hand-written sequences cover halt and clr during
// an instruction.
// -----------------------------------------------------------------------------
module tb_sap_control_sequencer;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    typedef struct {
        logic        clr;
        logic [15:0] instr;
        logic        chk;
        logic [5:0]  t;
        logic [11:0] w;
        logic        h;
        logic        e;
    } vec_t;

    typedef struct {
        int          tag;
        logic [5:0]  t;
        logic [11:0] w;
        logic        h;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] instr_onehot = 16'h0000;
    logic [5:0]  t_state;
    logic [11:0] con;
    logic        halt;
    logic        decode_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   tag_ctr  = 0;
    vec_t tbl[$];
    exp_t sb[$];
    exp_t mon_e;

    sap_control_sequencer dut (
        .clk          (clk),
        .clr          (clr),
        .instr_onehot (instr_onehot),
        .t_state      (t_state),
        .con          (con),
        .halt         (halt),
        .decode_err   (decode_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int tag,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, tag, act, exp);
        end
    endtask

    // Monitor: compare the oldest outstanding expectation on each falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("t_state",    mon_e.tag, {26'd0, t_state},    {26'd0, mon_e.t});
            check("con",        mon_e.tag, {20'd0, con},        {20'd0, mon_e.w});
            check("halt",       mon_e.tag, {31'd0, halt},       {31'd0, mon_e.h});
            check("decode_err", mon_e.tag, {31'd0, decode_err}, {31'd0, mon_e.e});
        end
    end

    function automatic void row(input logic c, input logic [15:0] i, input logic k,
                                input logic [5:0] t, input logic [11:0] w,
                                input logic h, input logic e);
        vec_t v;
        v.clr = c; v.instr = i; v.chk = k; v.t = t; v.w = w; v.h = h; v.e = e;
        tbl.push_back(v);
    endfunction

    // One whole instruction: the opcode is held for all six T-states.
    function automatic void instr_rows(input logic [15:0] i, input logic [11:0] w4,
                                       input logic [11:0] w5, input logic [11:0] w6,
                                       input logic e);
        row(1'b0, i, 1'b1, S1, 12'h600, 1'b0, e);
        row(1'b0, i, 1'b1, S2, 12'h800, 1'b0, e);
        row(1'b0, i, 1'b1, S3, 12'h180, 1'b0, e);
        row(1'b0, i, 1'b1, S4, w4,      1'b0, e);
        row(1'b0, i, 1'b1, S5, w5,      1'b0, e);
        row(1'b0, i, 1'b1, S6, w6,      1'b0, e);
    endfunction

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic step(input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        clr          = v.clr;
        instr_onehot = v.instr;
        if (v.chk) begin
            e.tag = tag_ctr; e.t = v.t; e.w = v.w; e.h = v.h; e.e = v.e;
            sb.push_back(e);
        end
        tag_ctr++;
    endtask

    task automatic cyc(input logic c, input logic [15:0] i, input logic [5:0] t,
                       input logic [11:0] w, input logic h, input logic e);
        vec_t v;
        v.clr = c; v.instr = i; v.chk = 1'b1; v.t = t; v.w = w; v.h = h; v.e = e;
        step(v);
    endtask

    initial begin
        // Reset held for two edges; outputs before the first edge are unknown.
        row(1'b1, 16'h0000, 1'b0, S1, 12'h000, 1'b0, 1'b0);
        row(1'b1, 16'h0000, 1'b0, S1, 12'h000, 1'b0, 1'b0);
        instr_rows(16'h0002, 12'h240, 12'h102, 12'h024, 1'b0);  // ADD
        instr_rows(16'h0004, 12'h240, 12'h102, 12'h02C, 1'b0);  // SUB
        instr_rows(16'h0001, 12'h240, 12'h120, 12'h000, 1'b0);  // LDA
        instr_rows(16'h4000, 12'h011, 12'h000, 12'h000, 1'b0);  // OUT
        instr_rows(16'h0020, 12'h000, 12'h000, 12'h000, 1'b0);  // unassigned -> NOP
        // Legal LDA in T4, then the decoder moves to ADD: words follow it.
        row(1'b0, 16'h0001, 1'b1, S1, 12'h600, 1'b0, 1'b0);
        row(1'b0, 16'h0001, 1'b1, S2, 12'h800, 1'b0, 1'b0);
        row(1'b0, 16'h0001, 1'b1, S3, 12'h180, 1'b0, 1'b0);
        row(1'b0, 16'h0001, 1'b1, S4, 12'h240, 1'b0, 1'b0);
        row(1'b0, 16'h0002, 1'b1, S5, 12'h102, 1'b0, 1'b0);
        row(1'b0, 16'h0002, 1'b1, S6, 12'h024, 1'b0, 1'b0);
        // Zero opcode in T4: NOP through T6 even when ADD appears; flag sticks.
        row(1'b0, 16'h0000, 1'b1, S1, 12'h600, 1'b0, 1'b0);
        row(1'b0, 16'h0000, 1'b1, S2, 12'h800, 1'b0, 1'b0);
        row(1'b0, 16'h0000, 1'b1, S3, 12'h180, 1'b0, 1'b0);
        row(1'b0, 16'h0000, 1'b1, S4, 12'h000, 1'b0, 1'b0);
        row(1'b0, 16'h0002, 1'b1, S5, 12'h000, 1'b0, 1'b1);
        row(1'b0, 16'h0002, 1'b1, S6, 12'h000, 1'b0, 1'b1);
        instr_rows(16'h0002, 12'h240, 12'h102, 12'h024, 1'b1);  // valid ADD, flag kept
        instr_rows(16'h0003, 12'h000, 12'h000, 12'h000, 1'b1);  // two bits set
        instr_rows(16'h8001, 12'h000, 12'h000, 12'h000, 1'b1);  // HLT + LDA: no halt
        // clr clears the sticky flag.
        row(1'b1, 16'h0002, 1'b1, S1, 12'h600, 1'b0, 1'b1);
        instr_rows(16'h0002, 12'h240, 12'h102, 12'h024, 1'b0);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // HLT: halt rises combinationally in T4, then everything freezes.
        cyc(1'b0, 16'h8000, S1, 12'h600, 1'b0, 1'b0);
        cyc(1'b0, 16'h8000, S2, 12'h800, 1'b0, 1'b0);
        cyc(1'b0, 16'h8000, S3, 12'h180, 1'b0, 1'b0);
        cyc(1'b0, 16'h8000, S4, 12'h000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 16'h0002, S4, 12'h000, 1'b1, 1'b0);
        cyc(1'b1, 16'h0002, S4, 12'h000, 1'b1, 1'b0);
        cyc(1'b0, 16'h0002, S1, 12'h600, 1'b0, 1'b0);

        // clr during ADD T5: the T6 word must never appear.
        cyc(1'b0, 16'h0002, S2, 12'h800, 1'b0, 1'b0);
        cyc(1'b0, 16'h0002, S3, 12'h180, 1'b0, 1'b0);
        cyc(1'b0, 16'h0002, S4, 12'h240, 1'b0, 1'b0);
        cyc(1'b1, 16'h0002, S5, 12'h102, 1'b0, 1'b0);
        cyc(1'b0, 16'h0002, S1, 12'h600, 1'b0, 1'b0);
        cyc(1'b0, 16'h0002, S2, 12'h800, 1'b0, 1'b0);

        // Let the monitor drain the scoreboard, within a bounded wait.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        check("scoreboard_drain", tag_ctr, sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Ring-counter T-state generator and control matrix for the SAP CPU.
- Sits directly downstream of the 4-to-16 opcode decoder and consumes its one-hot instruction lines.
- Each instruction runs as a fixed 6-T-state cycle: T1–T3 fetch, T4–T6 execute.
- Drives the 12-bit control word to the PC, MAR, RAM, IR, accumulator, ALU, B and output registers, plus the halt line to the clock gate.

Parameters:
- LDA_OP, 0, one-hot index of LDA.
- ADD_OP, 1, one-hot index of ADD.
- SUB_OP, 2, one-hot index of SUB.
- OUT_OP, 14, one-hot index of OUT.
- HLT_OP, 15, one-hot index of HLT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset; synchronous, active-high.
- instr_onehot  input  16  one-hot opcode from the decoder; sampled only in T4–T6.
- t_state  output  6  one-hot T-state; bit0 = T1 … bit5 = T6.
- con  output  12  control word, all bits active-high. Bit order {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}, bit11 down to bit0.
- halt  output  1  stop request to the clock gate.
- decode_err  output  1  sticky flag: malformed opcode seen in T4.

Behaviour:
- Reset: clr sampled high at a rising edge gives:
  - t_state = 6'b000001
  - halted = 0
  - decode_err = 0
  - con therefore = 12'h600 (T1 word)
  - halt = 0
- clr has priority over every other event, including halt.
- Ring counter:
  - Rotates one position left per clock: T6 wraps to T1.
  - Advances every clock unless halted; no other stall condition.
- con is combinational from t_state and instr_onehot, with no registered latency. It is valid in the same cycle the T-state is entered.
- Fetch words, opcode-independent:
  - T1 = ep|lm = 12'h600
  - T2 = cp = 12'h800
  - T3 = ce|li = 12'h180
- Execute words:
  - LDA: T4 = ei|lm = 12'h240; T5 = ce|la = 12'h120; T6 = 12'h000.
  - ADD: T4 = 12'h240; T5 = ce|lb = 12'h102; T6 = eu|la = 12'h024.
  - SUB: T4 = 12'h240; T5 = 12'h102; T6 = su|eu|la = 12'h02C.
  - OUT: T4 = ea|lo = 12'h011; T5 = 12'h000; T6 = 12'h000.
  - HLT: T4–T6 = 12'h000.
  - Any other single-bit opcode: NOP, con = 12'h000 in T4–T6.
- Malformed opcode: instr_onehot zero or with more than one bit set, while in T4.
  - T4–T6 of that instruction execute as NOP (12'h000).
  - decode_err sets on the T4 edge and holds until clr.
  - Opcode legality is judged only in T4. Changes during T5/T6 still select words combinationally, but do not set decode_err.
- Halt:
  - halt = halted | (t_state[3] & instr_onehot[HLT_OP] & opcode well-formed).
  - On the rising edge in T4 with HLT valid, halted sets. t_state freezes at T4 from then on.
  - While halted: con = 12'h000 regardless of instr_onehot, and the counter does not move.
  - The only exit is clr, which returns to T1 with con = 12'h600 on the next cycle.
- Invariants:
  - t_state always exactly one-hot; never 0.
  - su never asserted without eu.
  - lm and la never asserted in the same T-state.

Test Plan:
- Reset: hold clr for 2 cycles, then release → t_state = 6'b000001, con = 12'h600, halt = 0, decode_err = 0. Next 2 clocks → con = 12'h800, then 12'h180.
- ADD then SUB: instr_onehot = 16'h0002 for 6 clocks, then 16'h0004 for 6 clocks.
  - T4–T6 con = 12'h240, 12'h102, 12'h024, then 12'h240, 12'h102, 12'h02C.
  - t_state returns to 6'b000001 after each T6.
- LDA / OUT: instr_onehot = 16'h0001 → T4/T5/T6 con = 12'h240/12'h120/12'h000. instr_onehot = 16'h4000 → T4 con = 12'h011, T5/T6 = 12'h000.
- HLT freeze:
  - instr_onehot = 16'h8000 → halt rises combinationally in T4.
  - After 10 further clocks: t_state = 6'b001000, con = 12'h000, halt = 1, even with instr_onehot changed to 16'h0002.
  - Pulse clr → t_state = 6'b000001, halt = 0, con = 12'h600.
- Malformed opcode: instr_onehot = 16'h0000 in T4 → con = 12'h000 in T4–T6, decode_err = 1 from the next cycle and through subsequent valid instructions. Repeat with 16'h0003 → same result. clr clears it.
- clr mid-instruction: during ADD T5 (con = 12'h102), assert clr for 1 cycle → next cycle t_state = 6'b000001, con = 12'h600, and the ADD T6 word never appears.
